// File: rtl/bip_control.sv
// bip_control: BIP control unit holding the PC, decoding instructions, tracking RUN/HALT and counting executed cycles
module bip_control #(
  parameter int NB_DATA            = 16,
  parameter int NB_OPCODE          = 5,
  parameter int NB_OPERAND         = 11,
  parameter int N_INSMEM_ADDR      = 2048,
  parameter int LOG2_N_INSMEM_ADDR = 11,
  parameter int LOG2_N_DATA_ADDR   = 10,
  parameter int NB_CYCLE_CNT       = 32
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_valid,
  input  logic [NB_DATA-1:0]            i_instruction,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_insmem_addr,
  output logic [LOG2_N_DATA_ADDR-1:0]   o_data_mem_addr,
  output logic [NB_OPERAND-1:0]         o_data_instruction,
  output logic [1:0]                    o_sel_a,
  output logic                          o_sel_b,
  output logic                          o_wr_acc,
  output logic                          o_op_code,
  output logic                          o_wr_ram,
  output logic                          o_rd_ram,
  output logic                          o_halted,
  output logic [NB_CYCLE_CNT-1:0]       o_cycle_count
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [NB_OPCODE-1:0] op;
  logic exec, alu;
  assign op                 = i_instruction[NB_DATA-1 -: NB_OPCODE];
  assign o_data_instruction = i_instruction[NB_OPERAND-1:0];
  assign o_data_mem_addr    = i_instruction[LOG2_N_DATA_ADDR-1:0];
  assign exec               = state_q == RUN && i_valid && !i_reset;
  assign alu                = op >= NB_OPCODE'(4) && op <= NB_OPCODE'(7);
  always_ff @(posedge i_clock)
    state_q <= i_reset ? RUN : state_d;
  always_comb
    state_d = exec && op == NB_OPCODE'(0) ? HALT : state_q;
  always_comb begin
    o_wr_acc  = exec && op >= NB_OPCODE'(2) && op <= NB_OPCODE'(7);
    o_wr_ram  = exec && op == NB_OPCODE'(1);
    o_rd_ram  = exec && (op == NB_OPCODE'(2) || op == NB_OPCODE'(4) || op == NB_OPCODE'(6));
    o_sel_a   = !exec ? 2'b00 : op == NB_OPCODE'(3) ? 2'b01 : alu ? 2'b10 : 2'b00;
    o_sel_b   = exec && (op == NB_OPCODE'(5) || op == NB_OPCODE'(7));
    o_op_code = exec && (op == NB_OPCODE'(4) || op == NB_OPCODE'(5));
    o_halted  = state_q == HALT && !i_reset;
  end
  always_ff @(posedge i_clock)
    if (i_reset) begin
      o_insmem_addr <= '0;
      o_cycle_count <= '0;
    end else if (exec) begin
      o_cycle_count <= &o_cycle_count ? o_cycle_count : o_cycle_count + NB_CYCLE_CNT'(1);
      if (op != NB_OPCODE'(0))
        o_insmem_addr <= o_insmem_addr == LOG2_N_INSMEM_ADDR'(N_INSMEM_ADDR - 1) ? '0
                         : o_insmem_addr + LOG2_N_INSMEM_ADDR'(1);
    end
endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
- Control unit for the BIP single-cycle processor; it is the instruction-side counterpart of the accumulator datapath.
- Holds the program counter and fetches from instruction memory (combinational read at o_insmem_addr).
- Decodes opcode/operand and drives datapath selects, accumulator write and data-memory strobes, one instruction per enabled cycle.
- Tracks RUN/HALT state and an executed-cycle counter for the debug unit.

Parameters:
- NB_DATA, 16, instruction word width
- NB_OPCODE, 5, opcode field width (instr[15:11])
- NB_OPERAND, 11, operand field width (instr[10:0])
- N_INSMEM_ADDR, 2048, instruction memory depth
- LOG2_N_INSMEM_ADDR, 11, PC width
- LOG2_N_DATA_ADDR, 10, data memory address width
- NB_CYCLE_CNT, 32, cycle counter width

Ports:
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  step enable; one instruction executes per cycle with i_valid=1
- i_instruction  in  NB_DATA  instruction word at o_insmem_addr
- o_insmem_addr  out  LOG2_N_INSMEM_ADDR  program counter
- o_data_mem_addr  out  LOG2_N_DATA_ADDR  operand[LOG2_N_DATA_ADDR-1:0]
- o_data_instruction  out  NB_OPERAND  operand field to datapath sign-extender
- o_sel_a  out  2  acc source: 00 data mem, 01 extended operand, 10 ALU
- o_sel_b  out  1  ALU operand B: 1 extended operand, 0 data mem
- o_wr_acc  out  1  accumulator write enable
- o_op_code  out  1  ALU: 1 add, 0 subtract
- o_wr_ram  out  1  data memory write strobe (data = accumulator)
- o_rd_ram  out  1  data memory read strobe
- o_halted  out  1  high in HALT state
- o_cycle_count  out  NB_CYCLE_CNT  executed-cycle counter

Behaviour:
- States: RUN, HALT. Reset -> RUN, PC=0, count=0.
- While i_reset=1, all strobes (o_wr_acc, o_wr_ram, o_rd_ram) are 0 in the same cycle. o_sel_a=00, o_sel_b=0, o_op_code=0, o_halted=0.
- Decode is combinational from i_instruction. Strobes are gated by exec = (state==RUN) & i_valid & ~i_reset. Effects commit at the next rising edge, so latency is zero cycles from instruction to strobe.
- o_data_instruction and o_data_mem_addr always reflect the operand field, ungated.
- Opcode table (others: wr_acc=0, wr_ram=0, rd_ram=0, sel_a=00, sel_b=0, op_code=0):
  - 00000 HLT: no strobes; next state HALT; PC holds.
  - 00001 STO: wr_ram=1.
  - 00010 LD: rd_ram=1, wr_acc=1, sel_a=00.
  - 00011 LDI: wr_acc=1, sel_a=01.
  - 00100 ADD: rd_ram=1, wr_acc=1, sel_a=10, sel_b=0, op_code=1.
  - 00101 ADDI: wr_acc=1, sel_a=10, sel_b=1, op_code=1.
  - 00110 SUB: rd_ram=1, wr_acc=1, sel_a=10, sel_b=0, op_code=0.
  - 00111 SUBI: wr_acc=1, sel_a=10, sel_b=1, op_code=0.
  - 01000-11111: NOP (no strobes), PC advances.
- PC: on exec and non-HLT, PC <= PC+1. At PC == N_INSMEM_ADDR-1 it wraps to 0. Without exec, PC holds.
- i_valid=0 in RUN: no strobes, PC/state/count hold, and the instruction is not consumed.
- HALT: all strobes 0, o_halted=1, PC frozen at the HLT address, i_valid ignored. HALT is exited only by i_reset.
- o_cycle_count increments on every exec cycle, including the HLT cycle. It saturates at all-ones (no wrap).
- Reset mid-program: the next edge forces PC=0, RUN, count=0. The instruction present during the reset cycle has no effect.

Test Plan:
- Reset, i_valid=1, program LDI 5; ADDI 3; STO 2; HLT -> strobes per table each cycle; wr_ram=1 at PC=2 with data addr 2; o_halted=1 from cycle 4; PC stays 3; count=4.
- LD 7; SUB 8 with i_valid toggling 1,0,1 -> PC 0,1,1,2; no strobes in the gap cycle; SUB gives op_code=0, sel_b=0, rd_ram=1.
- Opcode 11111 at PC=0x7FF (wrap) -> no strobes, PC becomes 0x000, count +1.
- Halted, i_valid=1 for 10 cycles -> PC, count and strobes unchanged; assert i_reset -> PC=0, o_halted=0 next cycle.
- i_reset asserted during an ADD cycle -> wr_acc=0 and rd_ram=0 that cycle; PC=0 and count=0 after the edge.
- Force count to all-ones minus 1, execute 3 NOPs -> count saturates at all-ones.
